// File: rtl/risc_trace_buffer.sv
// rtl/risc_trace_buffer.sv - retirement trace capture FIFO for the 16-bit RISC core
module risc_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int CW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     clr,
   input  logic [15:0]              pc_current,
   input  logic [15:0]              instr,
   input  logic                     reg_write,
   input  logic [2:0]               reg_write_dest,
   input  logic [15:0]              reg_write_data,
   input  logic                     mem_write,
   input  logic [15:0]              mem_access_addr,
   input  logic [15:0]              mem_write_data,
   output logic                     tr_valid,
   input  logic                     tr_ready,
   output logic [1:0]               tr_kind,
   output logic [CW-1:0]            tr_stamp,
   output logic [15:0]              tr_pc,
   output logic [15:0]              tr_instr,
   output logic [2:0]               tr_rd,
   output logic [15:0]              tr_rd_data,
   output logic [15:0]              tr_mem_addr,
   output logic [15:0]              tr_mem_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   localparam int AW = $clog2(DEPTH);
   // kind + stamp + pc + instr + rd + rd_data + mem_addr + mem_data
   localparam int RW = 2 + CW + 16 + 16 + 3 + 16 + 16 + 16;

   logic [CW-1:0] cycle_cnt;
   logic [RW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          capture;
   logic          empty;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;
   logic [RW-1:0] rec_in;
   logic [RW-1:0] head;

   // Capture/pop qualification; a pop frees the slot a same-cycle push needs when full.
   // tr_ready only feeds FIFO bookkeeping, never anything facing the core.
   always_comb begin
      capture = en && (reg_write || mem_write);
      empty   = (count == '0);
      full    = (count == (AW+1)'(DEPTH));
      pop     = !empty && tr_ready;
      push    = capture && (!full || pop);
      drop    = capture && full && !pop;
   end

   // Pack the retiring instruction; fields absent for this kind are stored as zero.
   always_comb begin
      rec_in = {mem_write, reg_write, cycle_cnt, pc_current, instr,
                reg_write ? reg_write_dest  : 3'd0,
                reg_write ? reg_write_data  : 16'd0,
                mem_write ? mem_access_addr : 16'd0,
                mem_write ? mem_write_data  : 16'd0};
   end

   // Free-running cycle stamp; advances only while capture is enabled and survives clr.
   always_ff @(posedge clk) begin
      if (rst)
         cycle_cnt <= '0;
      else if (en)
         cycle_cnt <= cycle_cnt + CW'(1);
   end

   // Pointer, occupancy and drop bookkeeping; clr outranks both push and pop.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= 8'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + (AW+1)'(1);
         else if (pop && !push)
            count <= count - (AW+1)'(1);
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF)
               drop_count <= drop_count + 8'd1;
         end
      end
   end

   // Record storage; entries need no reset because outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push && !rst && !clr)
         mem[wr_ptr] <= rec_in;
   end

   // Present the head entry, forced to zero when nothing is buffered.
   always_comb begin
      head = empty ? '0 : mem[rd_ptr];
   end

   assign {tr_kind, tr_stamp, tr_pc, tr_instr, tr_rd, tr_rd_data,
           tr_mem_addr, tr_mem_data} = head;
   assign tr_valid = !empty;
   assign level    = count;

endmodule

// File: tb/tb_risc_trace_buffer.sv
// tb/tb_risc_trace_buffer.sv - scoreboard bench for the retirement trace buffer
module tb_risc_trace_buffer;

   localparam int DEPTH = 16;
   localparam int CW    = 16;

   typedef struct packed {
      logic [1:0]    kind;
      logic [CW-1:0] stamp;
      logic [15:0]   pc;
      logic [15:0]   instr;
      logic [2:0]    rd;
      logic [15:0]   rd_data;
      logic [15:0]   mem_addr;
      logic [15:0]   mem_data;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] pc_current = '0;
   logic [15:0] instr = '0;
   logic        reg_write = 1'b0;
   logic [2:0]  reg_write_dest = '0;
   logic [15:0] reg_write_data = '0;
   logic        mem_write = 1'b0;
   logic [15:0] mem_access_addr = '0;
   logic [15:0] mem_write_data = '0;
   logic        tr_valid;
   logic        tr_ready = 1'b0;
   logic [1:0]  tr_kind;
   logic [CW-1:0] tr_stamp;
   logic [15:0] tr_pc;
   logic [15:0] tr_instr;
   logic [2:0]  tr_rd;
   logic [15:0] tr_rd_data;
   logic [15:0] tr_mem_addr;
   logic [15:0] tr_mem_data;
   logic [4:0]  level;
   logic        overflow;
   logic [7:0]  drop_count;

   rec_t          sb[$];
   logic [CW-1:0] m_cnt = '0;
   int            n_vec = 0;
   int            n_err = 0;

   risc_trace_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr),
      .pc_current(pc_current), .instr(instr),
      .reg_write(reg_write), .reg_write_dest(reg_write_dest), .reg_write_data(reg_write_data),
      .mem_write(mem_write), .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
      .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind), .tr_stamp(tr_stamp),
      .tr_pc(tr_pc), .tr_instr(tr_instr), .tr_rd(tr_rd), .tr_rd_data(tr_rd_data),
      .tr_mem_addr(tr_mem_addr), .tr_mem_data(tr_mem_data),
      .level(level), .overflow(overflow), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   function automatic rec_t dut_rec();
      return {tr_kind, tr_stamp, tr_pc, tr_instr, tr_rd, tr_rd_data, tr_mem_addr, tr_mem_data};
   endfunction

   function automatic rec_t mk_rec();
      rec_t r;
      r.kind     = {mem_write, reg_write};
      r.stamp    = m_cnt;
      r.pc       = pc_current;
      r.instr    = instr;
      r.rd       = reg_write ? reg_write_dest : 3'd0;
      r.rd_data  = reg_write ? reg_write_data : 16'd0;
      r.mem_addr = mem_write ? mem_access_addr : 16'd0;
      r.mem_data = mem_write ? mem_write_data : 16'd0;
      return r;
   endfunction

   task automatic drive(input bit rw, input bit mw);
      reg_write       = rw;
      mem_write       = mw;
      pc_current      = 16'($urandom);
      instr           = 16'($urandom);
      reg_write_dest  = 3'($urandom);
      reg_write_data  = 16'($urandom);
      mem_access_addr = 16'($urandom);
      mem_write_data  = 16'($urandom);
   endtask

   task automatic idle();
      reg_write = 1'b0;
      mem_write = 1'b0;
   endtask

   // Advance one clock; the scoreboard queue is updated with what the DUT should do at this edge.
   task automatic step();
      bit cap;
      bit pop;
      bit full;
      cap = en && (reg_write || mem_write);
      pop = (sb.size() != 0) && tr_ready;
      if (rst) begin
         sb.delete();
         m_cnt = '0;
      end else begin
         if (clr) begin
            sb.delete();
         end else begin
            full = (sb.size() == DEPTH);
            if (pop)
               void'(sb.pop_front());
            if (cap && (!full || pop))
               sb.push_back(mk_rec());
         end
         if (en)
            m_cnt = m_cnt + 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; clr = 1'b0; tr_ready = 1'b0; idle();
      step(); step();
      rst = 1'b0;
      n_vec++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", tr_valid); end
      n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
      n_vec++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_err++; $display("FAIL reset_ovf: got %b/%0d want 0/0", overflow, drop_count); end
      n_vec++; if (dut_rec() !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", dut_rec()); end
   endtask

   task automatic test_reg_write();
      rec_t got;
      en = 1'b1;
      reg_write = 1'b1; mem_write = 1'b0;
      pc_current = 16'h0004; instr = 16'h2281; reg_write_dest = 3'd3; reg_write_data = 16'h00A5;
      mem_access_addr = 16'h1234; mem_write_data = 16'h5678;
      step(); idle();
      got = dut_rec();
      n_vec++; if (tr_valid !== 1'b1 || level !== 5'd1) begin n_err++; $display("FAIL regw_valid: got %b/%0d want 1/1", tr_valid, level); end
      n_vec++; if (got.kind !== 2'b01 || got.stamp !== 16'h0000 || got.rd !== 3'd3 || got.rd_data !== 16'h00A5)
         begin n_err++; $display("FAIL regw_fields: got %h want kind 01 stamp 0 rd 3 data 00a5", got); end
      n_vec++; if (got.mem_addr !== 16'h0 || got.mem_data !== 16'h0) begin n_err++; $display("FAIL regw_memzero: got %h/%h want 0/0", got.mem_addr, got.mem_data); end
      n_vec++; if (got !== sb[0]) begin n_err++; $display("FAIL regw_sb: got %h want %h", got, sb[0]); end
      tr_ready = 1'b1; step(); tr_ready = 1'b0;
      n_vec++; if (tr_valid !== 1'b0 || level !== 5'd0) begin n_err++; $display("FAIL regw_drain: got %b/%0d want 0/0", tr_valid, level); end
   endtask

   task automatic test_store_and_both();
      rec_t got;
      drive(0, 1); mem_access_addr = 16'h0010; mem_write_data = 16'hBEEF; step();
      drive(1, 1); step(); idle();
      got = dut_rec();
      n_vec++; if (got.kind !== 2'b10 || got.mem_addr !== 16'h0010 || got.mem_data !== 16'hBEEF || got.rd !== 3'd0 || got.rd_data !== 16'd0)
         begin n_err++; $display("FAIL store_fields: got %h want kind 10 addr 0010 data beef rd 0", got); end
      tr_ready = 1'b1;
      while (sb.size() != 0) begin
         got = dut_rec();
         n_vec++; if (tr_valid !== 1'b1 || got !== sb[0]) begin n_err++; $display("FAIL store_drain: got %h want %h", got, sb[0]); end
         if (sb.size() == 1) begin
            n_vec++; if (got.kind !== 2'b11) begin n_err++; $display("FAIL both_kind: got %b want 11", got.kind); end
         end
         step();
      end
      tr_ready = 1'b0;
   endtask

   task automatic test_overflow();
      rec_t got;
      rst = 1'b1; step(); rst = 1'b0; en = 1'b1; tr_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin drive(1, i[0]); step(); end
      idle();
      n_vec++; if (level !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd4)
         begin n_err++; $display("FAIL ovf_state: got %0d/%b/%0d want 16/1/4", level, overflow, drop_count); end
      tr_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         got = dut_rec();
         n_vec++; if (tr_valid !== 1'b1 || got !== sb[0] || got.stamp !== CW'(i))
            begin n_err++; $display("FAIL ovf_drain[%0d]: got %h want %h stamp %0d", i, got, sb[0], i); end
         step();
      end
      tr_ready = 1'b0;
      n_vec++; if (tr_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", tr_valid); end
   endtask

   task automatic test_back_to_back();
      rec_t got;
      logic [15:0] last_pc;
      clr = 1'b1; step(); clr = 1'b0;
      for (int i = 0; i < 16; i++) begin drive(1, 0); step(); end
      drive(0, 1); last_pc = pc_current; tr_ready = 1'b1;
      got = dut_rec();
      n_vec++; if (got !== sb[0]) begin n_err++; $display("FAIL b2b_head: got %h want %h", got, sb[0]); end
      step(); idle(); tr_ready = 1'b0;
      n_vec++; if (level !== 5'd16 || drop_count !== 8'd0 || overflow !== 1'b0)
         begin n_err++; $display("FAIL b2b_full: got %0d/%0d/%b want 16/0/0", level, drop_count, overflow); end
      tr_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         got = dut_rec();
         n_vec++; if (got !== sb[0]) begin n_err++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, got, sb[0]); end
         if (i == 15) begin
            n_vec++; if (got.pc !== last_pc) begin n_err++; $display("FAIL b2b_last: got %h want %h", got.pc, last_pc); end
         end
         step();
      end
      tr_ready = 1'b0;
   endtask

   task automatic test_wrap();
      rec_t got;
      rst = 1'b1; step(); rst = 1'b0; en = 1'b1; idle();
      for (int i = 0; i < 65536; i++) step();
      drive(1, 0); step(); idle();
      got = dut_rec();
      n_vec++; if (got.stamp !== 16'h0000 || got !== sb[0]) begin n_err++; $display("FAIL wrap_stamp: got %h want %h", got, sb[0]); end
      en = 1'b0; drive(1, 1);
      for (int i = 0; i < 3; i++) step();
      idle();
      n_vec++; if (level !== 5'd1) begin n_err++; $display("FAIL en_off_level: got %0d want 1", level); end
      en = 1'b1; drive(0, 1); step(); idle();
      tr_ready = 1'b1;
      step();
      got = dut_rec();
      n_vec++; if (got.stamp !== 16'h0001 || got !== sb[0]) begin n_err++; $display("FAIL en_off_stamp: got %h want %h", got, sb[0]); end
      step(); tr_ready = 1'b0;
   endtask

   task automatic test_rst_clr();
      rec_t got;
      logic [CW-1:0] c;
      clr = 1'b1; step(); clr = 1'b0; tr_ready = 1'b0;
      for (int i = 0; i < 18; i++) begin drive(1, 1); step(); end
      idle(); tr_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         got = dut_rec();
         n_vec++; if (got !== sb[0]) begin n_err++; $display("FAIL clr_drain[%0d]: got %h want %h", i, got, sb[0]); end
         step();
      end
      n_vec++; if (level !== 5'd5 || tr_valid !== 1'b1 || overflow !== 1'b1 || drop_count !== 8'd2)
         begin n_err++; $display("FAIL clr_pre: got %0d/%b/%b/%0d want 5/1/1/2", level, tr_valid, overflow, drop_count); end
      c = m_cnt;
      clr = 1'b1; drive(1, 0); step(); clr = 1'b0; idle(); tr_ready = 1'b0;
      n_vec++; if (level !== 5'd0 || tr_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0 || dut_rec() !== '0)
         begin n_err++; $display("FAIL clr_post: got %0d/%b/%b/%0d want 0/0/0/0", level, tr_valid, overflow, drop_count); end
      drive(1, 0); step(); idle();
      got = dut_rec();
      n_vec++; if (got.stamp !== c + 16'd1 || got !== sb[0]) begin n_err++; $display("FAIL clr_stamp: got %h want stamp %h", got, c + 16'd1); end
      for (int i = 0; i < 4; i++) begin drive(0, 1); step(); end
      idle();
      n_vec++; if (level !== 5'd5 || tr_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre: got %0d/%b want 5/1", level, tr_valid); end
      tr_ready = 1'b1; rst = 1'b1; drive(1, 1); step(); rst = 1'b0; idle();
      n_vec++; if (level !== 5'd0 || tr_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0 || dut_rec() !== '0)
         begin n_err++; $display("FAIL rst_post: got %0d/%b/%b/%0d want 0/0/0/0", level, tr_valid, overflow, drop_count); end
      tr_ready = 1'b0;
      drive(1, 0); step(); idle();
      got = dut_rec();
      n_vec++; if (got.stamp !== 16'h0000 || got !== sb[0]) begin n_err++; $display("FAIL rst_stamp: got %h want %h", got, sb[0]); end
      tr_ready = 1'b1; step(); tr_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reg_write();
      test_store_and_both();
      test_overflow();
      test_back_to_back();
      test_wrap();
      test_rst_clr();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
